// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, payload MSB first, optional even
// parity bit, then a run of idle zeros before the next payload is accepted.
// dout and frame_done are flops; busy and tx_ready are decoded from the
// registered state.
module sync_frame_tx #(
    parameter int                DATA_W    = 8,
    parameter int                SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b1001,
    parameter int                PARITY_EN = 1,
    parameter int                GAP_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    // The counter must reach the longest per-state count without wrapping.
    localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_MAX = (MAX_SD > GAP_CYC) ? MAX_SD : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The first sync bit goes straight to dout on accept, so the shift
    // register only holds the remaining sync bits followed by the payload.
    localparam int SH_W = SYNC_W - 1 + DATA_W;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'(DATA_W - 2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  sh;
    logic             par_bit;
    logic             accept;

    assign tx_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

    // Frame sequencer: every output bit is registered together with the
    // state it belongs to, so dout lines up with the state in each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            par_bit    <= 1'b0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    dout <= 1'b0;
                    cnt  <= '0;
                    if (accept) begin
                        state   <= SYNC;
                        sh      <= {SYNC_WORD[SYNC_W-2:0], tx_data};
                        par_bit <= ^tx_data;
                        dout    <= SYNC_WORD[SYNC_W-1];
                    end
                end
                SYNC: begin
                    dout <= sh[SH_W-1];
                    sh   <= sh << 1;
                    if (cnt == SYNC_LAST) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == DATA_LAST) begin
                        cnt <= '0;
                        if (PARITY_EN != 0) begin
                            state      <= PAR;
                            dout       <= par_bit;
                            frame_done <= 1'b1;
                        end else begin
                            state <= GAP;
                            dout  <= 1'b0;
                        end
                    end else begin
                        dout       <= sh[SH_W-1];
                        sh         <= sh << 1;
                        cnt        <= cnt + 1'b1;
                        // Without parity the last payload bit ends the frame.
                        frame_done <= (PARITY_EN == 0) && (cnt == DATA_PEN);
                    end
                end
                PAR: begin
                    state <= GAP;
                    cnt   <= '0;
                    dout  <= 1'b0;
                end
                GAP: begin
                    dout <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: default instance plus a no-parity,
// 4-bit instance, with a registered 1001 detector listening to dout.
module tb_sync_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       dout;
    logic       busy;
    logic       frame_done;

    logic [3:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       dout2;
    logic       busy2;
    logic       frame_done2;

    int total = 0;
    int bad   = 0;

    sync_frame_tx #(
        .DATA_W(8), .SYNC_W(4), .SYNC_WORD(4'b1001), .PARITY_EN(1), .GAP_CYC(1)
    ) u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .dout(dout), .busy(busy), .frame_done(frame_done)
    );

    sync_frame_tx #(
        .DATA_W(4), .SYNC_W(4), .SYNC_WORD(4'b1001), .PARITY_EN(0), .GAP_CYC(1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .dout(dout2), .busy(busy2), .frame_done(frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered Mealy detector for the pattern 1001 (overlapping).
    logic [2:0] hist;
    logic       det;
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 3'b000;
            det  <= 1'b0;
        end else begin
            det  <= ({hist, dout} == 4'b1001);
            hist <= {hist[1:0], dout};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (!tx_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", {31'd0, tx_ready}, 32'd1);
    endtask

    // One frame on the default instance, with tx_valid pulsed while busy and
    // tx_data scrambled after accept; neither may disturb the frame.
    task automatic run_frame(input logic [7:0] d, input logic [12:0] exp_bits, input bit chk_det);
        @(negedge clk);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k <= 13) begin
                chk($sformatf("dout_%02h_c%0d", d, k), {31'd0, dout}, {31'd0, exp_bits[13-k]});
                chk($sformatf("done_%02h_c%0d", d, k), {31'd0, frame_done}, (k == 13) ? 32'd1 : 32'd0);
                chk($sformatf("busy_%02h_c%0d", d, k), {31'd0, busy}, 32'd1);
                if (chk_det)
                    chk($sformatf("det_%02h_c%0d", d, k), {31'd0, det}, (k == 5) ? 32'd1 : 32'd0);
            end else if (k == 14) begin
                chk($sformatf("gap_dout_%02h", d), {31'd0, dout}, 32'd0);
                chk($sformatf("gap_busy_%02h", d), {31'd0, busy}, 32'd1);
                chk($sformatf("gap_done_%02h", d), {31'd0, frame_done}, 32'd0);
            end else begin
                chk($sformatf("idle_busy_%02h", d), {31'd0, busy}, 32'd0);
                chk($sformatf("idle_dout_%02h", d), {31'd0, dout}, 32'd0);
                chk($sformatf("idle_ready_%02h", d), {31'd0, tx_ready}, 32'd1);
            end
            tx_valid = (k <= 12) && (k % 3 == 0);
            tx_data  = 8'($urandom);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [12:0] bits;
        bit          det_chk;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [29:0] bb;
        logic [7:0]  exp2;

        vecs[0] = '{8'hA5, 13'b1001_10100101_0, 1'b0};
        vecs[1] = '{8'h01, 13'b1001_00000001_1, 1'b0};
        vecs[2] = '{8'h00, 13'b1001_00000000_0, 1'b1};
        vecs[3] = '{8'h3C, 13'b1001_00111100_0, 1'b0};
        vecs[4] = '{8'hC3, 13'b1001_11000011_0, 1'b0};
        vecs[5] = '{8'h7F, 13'b1001_01111111_1, 1'b0};
        vecs[6] = '{8'hFF, 13'b1001_11111111_0, 1'b0};

        rst       = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data2  = 4'h0;
        tx_valid2 = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_dout2", {31'd0, dout2}, 32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("post_rst_ready2", {31'd0, tx_ready2}, 32'd1);

        foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].bits, vecs[i].det_chk);

        // Back-to-back with tx_valid held high: 3C then C3.
        @(negedge clk);
        wait_ready();
        bb       = {13'b1001_00111100_0, 2'b00, 13'b1001_11000011_0, 2'b00};
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) tx_data = 8'hC3;
            chk($sformatf("b2b_dout_c%0d", k), {31'd0, dout}, {31'd0, bb[30-k]});
            chk($sformatf("b2b_done_c%0d", k), {31'd0, frame_done},
                (k == 13 || k == 28) ? 32'd1 : 32'd0);
        end
        tx_valid = 1'b0;

        // Reset in the middle of a frame.
        @(negedge clk);
        wait_ready();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            if (k <= 5)
                chk($sformatf("abort_pre_c%0d", k), {31'd0, dout}, {31'd0, vecs[0].bits[13-k]});
        end
        rst = 1'b1;
        for (int k = 7; k <= 18; k++) begin
            @(negedge clk);
            rst = 1'b0;
            chk($sformatf("abort_dout_c%0d", k), {31'd0, dout}, 32'd0);
            chk($sformatf("abort_busy_c%0d", k), {31'd0, busy}, 32'd0);
            chk($sformatf("abort_done_c%0d", k), {31'd0, frame_done}, 32'd0);
        end
        run_frame(8'hA5, 13'b1001_10100101_0, 1'b0);

        // Reset wins over a simultaneous accept.
        @(negedge clk);
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        rst      = 1'b0;
        tx_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_acc_busy_c%0d", k), {31'd0, busy}, 32'd0);
            chk($sformatf("rst_acc_dout_c%0d", k), {31'd0, dout}, 32'd0);
        end
        run_frame(8'h01, 13'b1001_00000001_1, 1'b0);

        // No-parity 4-bit instance: 1001 1111, then straight into the gap.
        @(negedge clk);
        chk("np_ready", {31'd0, tx_ready2}, 32'd1);
        exp2      = 8'b1001_1111;
        tx_data2  = 4'hF;
        tx_valid2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            tx_valid2 = 1'b0;
            tx_data2  = 4'h0;
            if (k <= 8) begin
                chk($sformatf("np_dout_c%0d", k), {31'd0, dout2}, {31'd0, exp2[8-k]});
                chk($sformatf("np_done_c%0d", k), {31'd0, frame_done2}, (k == 8) ? 32'd1 : 32'd0);
                chk($sformatf("np_busy_c%0d", k), {31'd0, busy2}, 32'd1);
            end else if (k == 9) begin
                chk("np_gap_dout", {31'd0, dout2}, 32'd0);
                chk("np_gap_busy", {31'd0, busy2}, 32'd1);
                chk("np_gap_done", {31'd0, frame_done2}, 32'd0);
            end else begin
                chk("np_idle_busy", {31'd0, busy2}, 32'd0);
                chk("np_idle_ready", {31'd0, tx_ready2}, 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_frame_tx.md
SYNC_FRAME_TX -- requirements
Module: sync_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (4..16).
REQ-002 Parameter SYNC_W, default 4, sync word width in bits (2..8).
REQ-003 Parameter SYNC_WORD, default 4'b1001, sync pattern, sent MSB first.
REQ-004 Parameter PARITY_EN, default 1, appends an even-parity bit after the payload when 1.
REQ-005 Parameter GAP_CYC, default 1, number of idle '0' bit-cycles after each frame (1..4).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 tx_data  input  DATA_W  payload to serialize, sampled on accept.
REQ-009 tx_valid  input  1  payload request.
REQ-010 tx_ready  output  1  block can accept a payload this cycle.
REQ-011 dout  output  1  registered serial bit stream, one bit per clock.
REQ-012 busy  output  1  frame in progress (SYNC, DATA, PAR or GAP state).
REQ-013 frame_done  output  1  one-cycle pulse marking the last frame bit on dout.

Function
REQ-014 The FSM SHALL have the states IDLE, SYNC, DATA, PAR and GAP, with one bit counter shared across states.
REQ-015 tx_ready SHALL be 1 only in IDLE and outside reset; tx_ready SHALL be combinational from state only.
REQ-016 Accept SHALL occur when tx_valid and tx_ready are both 1 in a cycle. tx_data SHALL be captured into a shift register on accept.
REQ-017 In the cycle after accept (N+1), the state SHALL be SYNC and dout SHALL carry SYNC_WORD[SYNC_W-1].
REQ-018 SYNC SHALL drive SYNC_WORD MSB to LSB for SYNC_W cycles, then DATA.
REQ-019 DATA SHALL drive the captured payload MSB first for DATA_W cycles, then go to PAR if PARITY_EN is 1, else to GAP.
REQ-020 PAR SHALL drive XOR of all captured payload bits for one cycle, so the ones count over payload plus parity is even.
REQ-021 GAP SHALL drive dout=0 for GAP_CYC cycles, then return to IDLE.
REQ-022 In IDLE, dout SHALL be 0.
REQ-023 frame_done SHALL be 1 exactly in the cycle dout carries the last payload or parity bit, and 0 at all other times.
REQ-024 Frame length on dout SHALL be SYNC_W+DATA_W+PARITY_EN cycles. Accept-to-accept minimum SHALL be that length +GAP_CYC+1 cycles.
REQ-025 tx_valid while busy SHALL be ignored; no capture, and the frame in flight SHALL be unaffected.
REQ-026 Changes on tx_data after accept SHALL NOT affect the frame in flight.
REQ-027 With tx_valid held 1 continuously, the block SHALL accept once per IDLE entry, giving back-to-back frames separated by exactly GAP_CYC zeros plus one IDLE zero.
REQ-028 Counter widths SHALL cover max(SYNC_W, DATA_W, GAP_CYC) without wrap. The counter SHALL reset to 0 on every state change.

Reset
REQ-029 When rst is 1 at a clock edge, the state SHALL become IDLE, and the counter and shift register SHALL be cleared.
REQ-030 Reset values: dout=0, busy=0, frame_done=0; tx_ready=1 from the first cycle after rst deasserts.
REQ-031 Reset during a frame SHALL abort it at once, with no frame_done and no further frame bits.
REQ-032 rst SHALL take priority over a simultaneous accept; the payload SHALL be dropped.

Verification
REQ-033 Defaults, tx_data=8'hA5, accept at cycle 0 -> dout in cycles 1..13 = 1001 10100101 0; frame_done at cycle 13; dout=0 and busy=1 at cycle 14; tx_ready=1 at cycle 15.
REQ-034 tx_data=8'h01 -> parity bit=1; tx_data=8'h00 -> dout = 1001 00000000 0.
REQ-035 tx_valid held 1 with payloads 8'h3C then 8'hC3 -> second frame's first sync bit appears exactly 2 zero cycles after the first frame_done.
REQ-036 rst pulsed at cycle 6 of a frame -> dout=0, busy=0 and no frame_done from the next cycle; a new accept then yields a complete, correct frame.
REQ-037 Interop: dout fed to the team's registered 1001 Mealy detector with tx_data=8'h00 -> detector output =1 exactly one cycle after the 4th sync bit, and 0 for the remainder of the frame.
REQ-038 PARITY_EN=0, DATA_W=4, tx_data=4'hF -> dout = 1001 1111, followed directly by GAP; frame_done on the 8th bit.
